// File: rtl/execute_stage_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | execute_stage_if : E-register inputs, forwarding and M-register bus    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface execute_stage_if #(
    parameter int DATA_W = 64
);
    logic [3:0]        E_icode;
    logic [3:0]        E_ifun;
    logic [DATA_W-1:0] E_valA;
    logic [DATA_W-1:0] E_valB;
    logic [DATA_W-1:0] E_valC;
    logic [3:0]        E_dstE;
    logic [3:0]        E_dstM;
    logic [1:0]        E_stat;
    logic [1:0]        m_stat;
    logic [1:0]        W_stat;
    logic              M_bubble;
    logic [DATA_W-1:0] e_valE;
    logic [3:0]        e_dstE;
    logic              e_Cnd;
    logic [3:0]        M_icode;
    logic              M_Cnd;
    logic [DATA_W-1:0] M_valE;
    logic [DATA_W-1:0] M_valA;
    logic [3:0]        M_dstE;
    logic [3:0]        M_dstM;
    logic [1:0]        M_stat;

    modport master (
        output E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM, E_stat,
        output m_stat, W_stat, M_bubble,
        input  e_valE, e_dstE, e_Cnd,
        input  M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, M_stat
    );

    modport slave (
        input  E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM, E_stat,
        input  m_stat, W_stat, M_bubble,
        output e_valE, e_dstE, e_Cnd,
        output M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, M_stat
    );
endinterface
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | execute_stage : Y86-64 execute - ALU, condition codes, M register      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module execute_stage #(
    parameter int         DATA_W = 64,
    parameter logic [3:0] RNONE  = 4'hF
) (
    input  logic          clk,
    input  logic          reset,
    execute_stage_if.slave ex
);
    localparam logic [DATA_W-1:0] C_NEG8   = ~DATA_W'(7);
    localparam logic [DATA_W-1:0] C_POS8   = DATA_W'(8);
    localparam logic [1:0]        C_FN_ADD = 2'd0;
    localparam logic [1:0]        C_FN_SUB = 2'd1;
    localparam logic [1:0]        C_FN_AND = 2'd2;
    localparam logic [1:0]        C_FN_XOR = 2'd3;
    localparam int                C_MSB    = DATA_W - 1;

    logic [DATA_W-1:0] w_alu_a;
    logic [DATA_W-1:0] w_alu_b;
    logic [DATA_W-1:0] w_res;
    logic [1:0]        w_fn;
    logic              w_of;
    logic              w_set_cc;
    logic              w_cnd;
    logic [3:0]        w_dst_e;
    logic              r_zf;
    logic              r_sf;
    logic              r_of;

    always_comb begin
        w_alu_a = '0;
        w_alu_b = '0;
        case (ex.E_icode)
            4'h2, 4'h6:       w_alu_a = ex.E_valA;
            4'h3, 4'h4, 4'h5: w_alu_a = ex.E_valC;
            4'h8, 4'hA:       w_alu_a = C_NEG8;
            4'h9, 4'hB:       w_alu_a = C_POS8;
            default:          w_alu_a = '0;
        endcase
        case (ex.E_icode)
            4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: w_alu_b = ex.E_valB;
            default:                                  w_alu_b = '0;
        endcase
    end

    always_comb begin
        w_fn = C_FN_ADD;
        if (ex.E_icode == 4'h6) begin
            case (ex.E_ifun)
                4'h1:    w_fn = C_FN_SUB;
                4'h2:    w_fn = C_FN_AND;
                4'h3:    w_fn = C_FN_XOR;
                default: w_fn = C_FN_ADD;
            endcase
        end
    end

    always_comb begin
        w_res = w_alu_b + w_alu_a;
        w_of  = (w_alu_a[C_MSB] == w_alu_b[C_MSB]) && (w_res[C_MSB] != w_alu_a[C_MSB]);
        case (w_fn)
            C_FN_SUB: begin
                w_res = w_alu_b - w_alu_a;
                w_of  = (w_alu_a[C_MSB] != w_alu_b[C_MSB]) && (w_res[C_MSB] != w_alu_b[C_MSB]);
            end
            C_FN_AND: begin
                w_res = w_alu_a & w_alu_b;
                w_of  = 1'b0;
            end
            C_FN_XOR: begin
                w_res = w_alu_a ^ w_alu_b;
                w_of  = 1'b0;
            end
            default: ;
        endcase
    end

    // Condition is evaluated from the CC already latched, so an OPq never sees its own flags.
    always_comb begin
        w_cnd = 1'b0;
        case (ex.E_ifun)
            4'h0:    w_cnd = 1'b1;
            4'h1:    w_cnd = (r_sf ^ r_of) | r_zf;
            4'h2:    w_cnd = r_sf ^ r_of;
            4'h3:    w_cnd = r_zf;
            4'h4:    w_cnd = ~r_zf;
            4'h5:    w_cnd = ~(r_sf ^ r_of);
            4'h6:    w_cnd = ~(r_sf ^ r_of) & ~r_zf;
            default: w_cnd = 1'b0;
        endcase
    end

    assign w_dst_e  = ((ex.E_icode == 4'h2) && !w_cnd) ? RNONE : ex.E_dstE;
    assign w_set_cc = (ex.E_icode == 4'h6) && (ex.m_stat == 2'd0) && (ex.W_stat == 2'd0) && !reset;

    assign ex.e_valE = w_res;
    assign ex.e_dstE = w_dst_e;
    assign ex.e_Cnd  = w_cnd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_zf <= 1'b1;
            r_sf <= 1'b0;
            r_of <= 1'b0;
        end else if (w_set_cc) begin
            r_zf <= (w_res == '0);
            r_sf <= w_res[C_MSB];
            r_of <= w_of;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || ex.M_bubble) begin
            ex.M_icode <= 4'h1;
            ex.M_Cnd   <= 1'b0;
            ex.M_valE  <= '0;
            ex.M_valA  <= '0;
            ex.M_dstE  <= RNONE;
            ex.M_dstM  <= RNONE;
            ex.M_stat  <= 2'd0;
        end else begin
            ex.M_icode <= ex.E_icode;
            ex.M_Cnd   <= w_cnd;
            ex.M_valE  <= w_res;
            ex.M_valA  <= ex.E_valA;
            ex.M_dstE  <= w_dst_e;
            ex.M_dstM  <= ex.E_dstM;
            ex.M_stat  <= ex.E_stat;
        end
    end
endmodule
`default_nettype wire
